// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the direct-mapped write-through L1 data cache.
// Address field widths here correspond to the default geometry.
package cache_pkg;

  localparam int CACHE_SETS       = 8;
  localparam int CACHE_BLOCK_SIZE = 4;

  localparam int OFFSET_W = $clog2(CACHE_BLOCK_SIZE);
  localparam int INDEX_W  = $clog2(CACHE_SETS);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MISS_WAIT = 2'b01,
    WT_WAIT   = 2'b10,
    DONE      = 2'b11
  } cache_state_t;

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage for the data cache: one combinational read port,
// a whole-line fill port and a single-word update port.
module cache_array
  import cache_pkg::*;
#(
  parameter int SETS       = CACHE_SETS,
  parameter int BLOCK_SIZE = CACHE_BLOCK_SIZE
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [$clog2(SETS)-1:0]       rd_index,
  output logic                          rd_valid,
  output logic [31-$clog2(SETS)-$clog2(BLOCK_SIZE)-2:0] rd_tag,
  output logic [32*BLOCK_SIZE-1:0]      rd_line,
  input  logic                          fill_en,
  input  logic [$clog2(SETS)-1:0]       fill_index,
  input  logic [31-$clog2(SETS)-$clog2(BLOCK_SIZE)-2:0] fill_tag,
  input  logic [32*BLOCK_SIZE-1:0]      fill_data,
  input  logic                          word_en,
  input  logic [$clog2(SETS)-1:0]       word_index,
  input  logic [$clog2(BLOCK_SIZE)-1:0] word_offset,
  input  logic [31:0]                   word_data
);

  localparam int IW     = $clog2(SETS);
  localparam int OW     = $clog2(BLOCK_SIZE);
  localparam int TW     = 32 - IW - OW - 2;
  localparam int LINE_W = 32 * BLOCK_SIZE;

  logic [SETS-1:0]   valid_q;
  logic [TW-1:0]     tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  // Tag and data need no reset: a line is only read through its valid bit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
      tag_q[fill_index]   <= fill_tag;
      data_q[fill_index]  <= fill_data;
    end else if (word_en) begin
      data_q[word_index][32*word_offset +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-allocate, write-through L1 data cache between MEM stage and
// block-oriented data memory. Hits cost nothing; misses and write-throughs stall.
//
//   state     | meaning
//   IDLE      | serve hits, issue one-cycle request pulse on miss / store
//   MISS_WAIT | block read outstanding, fill line on ReadReady
//   WT_WAIT   | write-through outstanding, wait for WriteReady
//   DONE      | one released cycle; the held instruction now hits
module data_cache
  import cache_pkg::*;
#(
  parameter int SETS       = CACHE_SETS,
  parameter int BLOCK_SIZE = CACHE_BLOCK_SIZE
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [31:0]              Address,
  input  logic [31:0]              Write_data,
  output logic [31:0]              Read_data,
  output logic                     Stall,
  output logic [31:0]              Mem_Address,
  output logic [31:0]              Mem_Write_data,
  output logic                     ReadMiss,
  output logic                     MemWriteThrough,
  input  logic [32*BLOCK_SIZE-1:0] Mem_Read_data,
  input  logic                     ReadReady,
  input  logic                     WriteReady
);

  localparam int OW     = $clog2(BLOCK_SIZE);
  localparam int IW     = $clog2(SETS);
  localparam int TW     = 32 - IW - OW - 2;
  localparam int LINE_W = 32 * BLOCK_SIZE;

  logic [OW-1:0] cur_off;
  logic [IW-1:0] cur_idx;
  logic [TW-1:0] cur_tag;
  logic          unused_byte_bits;

  assign cur_off          = Address[OW+1:2];
  assign cur_idx          = Address[OW+IW+1:OW+2];
  assign cur_tag          = Address[31:OW+IW+2];
  assign unused_byte_bits = ^Address[1:0];

  cache_state_t state_q, state_d;
  logic [31:2]  req_addr_q;
  logic         sw_flag_q;
  logic [31:0]  sw_word_q;
  logic [31:0]  mem_addr_q;
  logic [31:0]  mem_wdata_q;

  logic              rd_valid;
  logic [TW-1:0]     rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit;
  logic              fill_en;
  logic              word_en;
  logic              latch_req;
  logic              set_sw;
  logic [31:0]       issue_addr;
  logic [31:0]       issue_wdata;
  logic [LINE_W-1:0] fill_data;

  assign hit       = rd_valid && (rd_tag == cur_tag);
  assign Read_data = rd_line[32*cur_off +: 32];

  always_comb begin
    state_d         = state_q;
    Stall           = 1'b0;
    ReadMiss        = 1'b0;
    MemWriteThrough = 1'b0;
    issue_addr      = mem_addr_q;
    issue_wdata     = mem_wdata_q;
    latch_req       = 1'b0;
    set_sw          = 1'b0;
    fill_en         = 1'b0;
    word_en         = 1'b0;
    if (!Rst) begin
      case (state_q)
        IDLE: begin
          if (MemWrite) begin
            Stall           = 1'b1;
            MemWriteThrough = 1'b1;
            issue_wdata     = Write_data;
            latch_req       = 1'b1;
            if (hit) begin
              word_en    = 1'b1;
              issue_addr = Address;
              state_d    = WT_WAIT;
            end else begin
              ReadMiss   = 1'b1;
              issue_addr = {Address[31:OW+2], {(OW+2){1'b0}}};
              set_sw     = 1'b1;
              state_d    = MISS_WAIT;
            end
          end else if (MemRead && !hit) begin
            Stall      = 1'b1;
            ReadMiss   = 1'b1;
            issue_addr = {Address[31:OW+2], {(OW+2){1'b0}}};
            latch_req  = 1'b1;
            state_d    = MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          Stall = 1'b1;
          if (ReadReady) begin
            fill_en = 1'b1;
            state_d = DONE;
          end
        end
        WT_WAIT: begin
          Stall = 1'b1;
          if (WriteReady) state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    Mem_Address    = issue_addr;
    Mem_Write_data = issue_wdata;
  end

  // The returned block predates the memory's own write, so merge the store word.
  always_comb begin
    fill_data = Mem_Read_data;
    if (sw_flag_q) fill_data[32*req_addr_q[OW+1:2] +: 32] = sw_word_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      sw_flag_q   <= 1'b0;
      sw_word_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= issue_addr;
      mem_wdata_q <= issue_wdata;
      if (latch_req) begin
        req_addr_q <= Address[31:2];
        sw_flag_q  <= set_sw;
        sw_word_q  <= Write_data;
      end else if (fill_en) begin
        sw_flag_q <= 1'b0;
      end
    end
  end

  cache_array #(
    .SETS       (SETS),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_array (
    .Clk         (Clk),
    .Rst         (Rst),
    .rd_index    (cur_idx),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_line     (rd_line),
    .fill_en     (fill_en),
    .fill_index  (req_addr_q[OW+IW+1:OW+2]),
    .fill_tag    (req_addr_q[31:OW+IW+2]),
    .fill_data   (fill_data),
    .word_en     (word_en),
    .word_index  (cur_idx),
    .word_offset (cur_off),
    .word_data   (Write_data)
  );

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a small latency-modelled block memory.
module tb_data_cache;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 3;

  logic         Clk;
  logic         Rst;
  logic         MemRead;
  logic         MemWrite;
  logic [31:0]  Address;
  logic [31:0]  Write_data;
  logic [31:0]  Read_data;
  logic         Stall;
  logic [31:0]  Mem_Address;
  logic [31:0]  Mem_Write_data;
  logic         ReadMiss;
  logic         MemWriteThrough;
  logic [127:0] Mem_Read_data;
  logic         ReadReady;
  logic         WriteReady;

  data_cache dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Address         (Address),
    .Write_data      (Write_data),
    .Read_data       (Read_data),
    .Stall           (Stall),
    .Mem_Address     (Mem_Address),
    .Mem_Write_data  (Mem_Write_data),
    .ReadMiss        (ReadMiss),
    .MemWriteThrough (MemWriteThrough),
    .Mem_Read_data   (Mem_Read_data),
    .ReadReady       (ReadReady),
    .WriteReady      (WriteReady)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: requests sampled mid-cycle, ready raised RD_LAT / WR_LAT cycles later.
  logic [31:0]  mem_words [256];
  logic [127:0] rd_blk;
  logic [31:0]  wr_addr, wr_data;
  int           rd_cnt = 0;
  int           wr_cnt = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = 32'h1000 + i;
    for (int i = 0; i < 4; i++) mem_words[16+i] = i + 1;
    ReadReady     = 1'b0;
    WriteReady    = 1'b0;
    Mem_Read_data = '0;
  end

  always @(negedge Clk) begin
    ReadReady  = 1'b0;
    WriteReady = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        ReadReady     = 1'b1;
        Mem_Read_data = rd_blk;
      end
    end
    if (wr_cnt > 0) begin
      wr_cnt--;
      if (wr_cnt == 0) begin
        WriteReady = 1'b1;
        mem_words[wr_addr[9:2]] = wr_data;
      end
    end
    if (ReadMiss) begin
      for (int i = 0; i < 4; i++)
        rd_blk[32*i +: 32] = mem_words[(Mem_Address[9:2] & 8'hFC) + 8'(i)];
      rd_cnt = RD_LAT;
    end
    if (MemWriteThrough) begin
      wr_addr = Mem_Address;
      wr_data = Mem_Write_data;
      wr_cnt  = WR_LAT;
    end
  end

  logic        iss_rm, iss_wt;
  logic [31:0] iss_addr, iss_wd, rdata;
  int          stall_cnt, rm_pulses, wt_pulses;

  // Present one op, follow it until Stall drops, record what was seen.
  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    @(posedge Clk); #1;
    MemRead = rd; MemWrite = wr; Address = a; Write_data = wd;
    #1;
    iss_rm    = ReadMiss;
    iss_wt    = MemWriteThrough;
    iss_addr  = Mem_Address;
    iss_wd    = Mem_Write_data;
    stall_cnt = 0;
    rm_pulses = 0;
    wt_pulses = 0;
    while (Stall && stall_cnt < 100) begin
      rm_pulses += int'(ReadMiss);
      wt_pulses += int'(MemWriteThrough);
      stall_cnt++;
      @(posedge Clk); #2;
    end
    check_eq("stall_bound", 32'(stall_cnt >= 100), 32'd0);
    rdata = Read_data;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  int saw_stall;

  initial begin
    Rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    check_eq("rst_stall", 32'(Stall), 32'd0);
    check_eq("rst_readmiss", 32'(ReadMiss), 32'd0);
    check_eq("rst_wt", 32'(MemWriteThrough), 32'd0);
    check_eq("rst_mem_addr", Mem_Address, 32'h0);
    check_eq("rst_mem_wdata", Mem_Write_data, 32'h0);

    // 1: cold read miss then hit in the same line
    op(1'b1, 1'b0, 32'h40, 32'h0);
    check_eq("t1_rm", 32'(iss_rm), 32'd1);
    check_eq("t1_wt", 32'(iss_wt), 32'd0);
    check_eq("t1_addr", iss_addr, 32'h40);
    check_eq("t1_stall", 32'(stall_cnt), 32'(RD_LAT + 1));
    check_eq("t1_rm_pulses", 32'(rm_pulses), 32'd1);
    check_eq("t1_data", rdata, 32'd1);
    op(1'b1, 1'b0, 32'h48, 32'h0);
    check_eq("t1_hit_stall", 32'(stall_cnt), 32'd0);
    check_eq("t1_hit_rm", 32'(iss_rm), 32'd0);
    check_eq("t1_hit_data", rdata, 32'd3);

    // 2: store hit, write-through
    op(1'b0, 1'b1, 32'h44, 32'hAB);
    check_eq("t2_wt", 32'(iss_wt), 32'd1);
    check_eq("t2_rm", 32'(iss_rm), 32'd0);
    check_eq("t2_addr", iss_addr, 32'h44);
    check_eq("t2_wdata", iss_wd, 32'hAB);
    check_eq("t2_stall", 32'(stall_cnt), 32'(WR_LAT + 1));
    check_eq("t2_wt_pulses", 32'(wt_pulses), 32'd1);
    op(1'b1, 1'b0, 32'h44, 32'h0);
    check_eq("t2_hit_stall", 32'(stall_cnt), 32'd0);
    check_eq("t2_hit_data", rdata, 32'hAB);

    // 3: store miss allocates and merges
    op(1'b0, 1'b1, 32'h88, 32'h55);
    check_eq("t3_rm", 32'(iss_rm), 32'd1);
    check_eq("t3_wt", 32'(iss_wt), 32'd1);
    check_eq("t3_addr", iss_addr, 32'h80);
    check_eq("t3_wdata", iss_wd, 32'h55);
    check_eq("t3_stall", 32'(stall_cnt), 32'(RD_LAT + 1));
    check_eq("t3_wt_pulses", 32'(wt_pulses), 32'd1);
    op(1'b1, 1'b0, 32'h88, 32'h0);
    check_eq("t3_hit_stall", 32'(stall_cnt), 32'd0);
    check_eq("t3_merged", rdata, 32'h55);
    op(1'b1, 1'b0, 32'h8C, 32'h0);
    check_eq("t3_other_stall", 32'(stall_cnt), 32'd0);
    check_eq("t3_other", rdata, 32'h1023);

    // 4: conflict on index 4
    op(1'b1, 1'b0, 32'h40, 32'h0);
    check_eq("t4_hit40", 32'(stall_cnt), 32'd0);
    op(1'b1, 1'b0, 32'hC0, 32'h0);
    check_eq("t4_missC0", 32'(iss_rm), 32'd1);
    check_eq("t4_addrC0", iss_addr, 32'hC0);
    check_eq("t4_dataC0", rdata, 32'h1030);
    op(1'b1, 1'b0, 32'h40, 32'h0);
    check_eq("t4_remiss40", 32'(iss_rm), 32'd1);
    check_eq("t4_data40", rdata, 32'd1);
    op(1'b1, 1'b0, 32'h44, 32'h0);
    check_eq("t4_hit44_stall", 32'(stall_cnt), 32'd0);
    check_eq("t4_hit44", rdata, 32'hAB);

    // 5: reset during MISS_WAIT, late ReadReady must be ignored
    @(posedge Clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; Address = 32'h100;
    #1 check_eq("t5_rm", 32'(ReadMiss), 32'd1);
    @(posedge Clk); #1;
    Rst = 1'b1; MemRead = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    check_eq("t5_stall", 32'(Stall), 32'd0);
    check_eq("t5_mem_addr", Mem_Address, 32'h0);
    saw_stall = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #2;
      saw_stall += int'(Stall) + int'(ReadMiss);
    end
    check_eq("t5_idle_quiet", 32'(saw_stall), 32'd0);
    op(1'b1, 1'b0, 32'h100, 32'h0);
    check_eq("t5_100_miss", 32'(iss_rm), 32'd1);
    check_eq("t5_100_data", rdata, 32'h1040);
    op(1'b1, 1'b0, 32'h48, 32'h0);
    check_eq("t5_valid_cleared", 32'(iss_rm), 32'd1);
    check_eq("t5_48_data", rdata, 32'd3);

    // 6: read and write together on a hit behave as a store
    op(1'b1, 1'b1, 32'h48, 32'h77);
    check_eq("t6_wt", 32'(iss_wt), 32'd1);
    check_eq("t6_rm", 32'(iss_rm), 32'd0);
    check_eq("t6_addr", iss_addr, 32'h48);
    check_eq("t6_stall", 32'(stall_cnt), 32'(WR_LAT + 1));
    check_eq("t6_rm_pulses", 32'(rm_pulses), 32'd0);
    op(1'b1, 1'b0, 32'h48, 32'h0);
    check_eq("t6_hit_stall", 32'(stall_cnt), 32'd0);
    check_eq("t6_data", rdata, 32'h77);

    @(posedge Clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    #1 check_eq("final_idle_stall", 32'(Stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
